// File: rtl/univ_reg.sv
// Universal WIDTH-bit register: parallel load, shift, rotate, increment and
// decrement, with synchronous clear, enable-gated hold and asynchronous reset.
module univ_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    logic [WIDTH-1:0] r_dout;
    logic             r_cout;

    logic [WIDTH-1:0] w_op_dout;
    logic             w_op_cout;
    logic [WIDTH-1:0] w_next_dout;
    logic             w_next_cout;

    // Result of the selected operation, evaluated as if en=1 and clr=0.
    always_comb begin
        w_op_dout = r_dout;
        w_op_cout = r_cout;
        unique case (mode)
            MODE_HOLD: begin
                w_op_dout = r_dout;
                w_op_cout = r_cout;
            end
            MODE_LOAD: begin
                w_op_dout = din;
                w_op_cout = 1'b0;
            end
            MODE_SHL: begin
                w_op_dout = {r_dout[WIDTH-2:0], sin};
                w_op_cout = r_dout[WIDTH-1];
            end
            MODE_SHR: begin
                w_op_dout = {sin, r_dout[WIDTH-1:1]};
                w_op_cout = r_dout[0];
            end
            MODE_ROL: begin
                w_op_dout = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
                w_op_cout = r_dout[WIDTH-1];
            end
            MODE_ROR: begin
                w_op_dout = {r_dout[0], r_dout[WIDTH-1:1]};
                w_op_cout = r_dout[0];
            end
            MODE_INC: begin
                w_op_dout = r_dout + WIDTH'(1);
                w_op_cout = &r_dout;
            end
            MODE_DEC: begin
                w_op_dout = r_dout - WIDTH'(1);
                w_op_cout = ~|r_dout;
            end
            default: begin
                w_op_dout = r_dout;
                w_op_cout = r_cout;
            end
        endcase
    end

    // Clear beats the enable gate, which beats the mode operation.
    always_comb begin
        w_next_dout = r_dout;
        w_next_cout = r_cout;
        if (clr) begin
            w_next_dout = '0;
            w_next_cout = 1'b0;
        end else if (en) begin
            w_next_dout = w_op_dout;
            w_next_cout = w_op_cout;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dout <= RESET_VAL;
            r_cout <= 1'b0;
        end else begin
            r_dout <= w_next_dout;
            r_cout <= w_next_cout;
        end
    end

    assign dout = r_dout;
    assign cout = r_cout;
    assign zero = (r_dout == '0);

endmodule

// File: doc/univ_reg.md
UNIV_REG -- requirements
Module: univ_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into dout on reset.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port en  input  1  operation enable; 0 = hold all state.
REQ-006 SHALL have port clr  input  1  synchronous clear; dout to 0 and cout to 0.
REQ-007 SHALL have port mode  input  3  operation select (see Function).
REQ-008 SHALL have port din  input  WIDTH  parallel load data.
REQ-009 SHALL have port sin  input  1  serial input bit for shift modes.
REQ-010 SHALL have port dout  output  WIDTH  registered register contents.
REQ-011 SHALL have port cout  output  1  registered carry/borrow/shifted-out bit.
REQ-012 SHALL have port zero  output  1  combinational; 1 when dout == 0.

Function
REQ-013 SHALL update dout/cout only on rising clock edge while reset is 1.
REQ-014 SHALL apply priority: reset > clr > en=0 (hold) > mode operation.
REQ-015 SHALL, with clr=1 (any en), set dout=0, cout=0 on the next edge.
REQ-016 SHALL, with en=0 and clr=0, hold dout and cout unchanged.
REQ-017 SHALL, with en=1, mode 000 (HOLD): dout and cout unchanged.
REQ-018 SHALL, mode 001 (LOAD): dout=din, cout=0.
REQ-019 SHALL, mode 010 (SHL): dout={dout[WIDTH-2:0],sin}, cout=old dout[WIDTH-1].
REQ-020 SHALL, mode 011 (SHR): dout={sin,dout[WIDTH-1:1]}, cout=old dout[0].
REQ-021 SHALL, mode 100 (ROL): dout={dout[WIDTH-2:0],dout[WIDTH-1]}, cout=old dout[WIDTH-1]; sin ignored.
REQ-022 SHALL, mode 101 (ROR): dout={dout[0],dout[WIDTH-1:1]}, cout=old dout[0]; sin ignored.
REQ-023 SHALL, mode 110 (INC): dout=dout+1 modulo 2^WIDTH, cout=1 only when old dout was all ones (wrap to 0).
REQ-024 SHALL, mode 111 (DEC): dout=dout-1 modulo 2^WIDTH, cout=1 only when old dout was 0 (wrap to all ones).
REQ-025 SHALL produce results with one-cycle latency: value visible on dout immediately after the capturing edge.
REQ-026 SHALL keep zero purely combinational from dout, with no extra register stage.
REQ-027 SHALL compute all arithmetic at exactly WIDTH bits; the carry/borrow appears only on cout.
REQ-028 SHALL ignore din in all modes except LOAD, and sin in all modes except SHL/SHR.

Reset
REQ-029 SHALL, on reset falling to 0, immediately (no clock needed) force dout=RESET_VAL, cout=0.
REQ-030 SHALL hold reset values for as long as reset=0, regardless of clock, en, clr, mode.
REQ-031 SHALL abort any operation in progress when reset asserts mid-cycle; no partial update.
REQ-032 SHALL resume normal operation at the first rising clock edge after reset returns to 1.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-033 SHALL verify: reset=0 mid-cycle with dout=0xA5 -> dout=0x00, cout=0, zero=1 before next edge; RESET_VAL=0x3C build -> dout=0x3C.
REQ-034 SHALL verify: LOAD 0x81, then SHL sin=0 -> dout=0x02, cout=1; then SHR sin=1 -> dout=0x81, cout=0.
REQ-035 SHALL verify: LOAD 0x81, ROL -> dout=0x03, cout=1; ROR -> dout=0x81, cout=1.
REQ-036 SHALL verify: LOAD 0xFF, INC -> dout=0x00, cout=1, zero=1; DEC -> dout=0xFF, cout=1; DEC -> dout=0xFE, cout=0.
REQ-037 SHALL verify: en=0 with mode=INC for 3 edges -> dout and cout unchanged; clr=1 with en=0 -> dout=0x00, cout=0 next edge.
REQ-038 SHALL verify: clr=1 and mode=LOAD din=0x55 same edge -> dout=0x00 (clr wins).
